// File: rtl/cu_seq_decoder.sv
// rtl/cu_seq_decoder.sv - sequenced instruction decoder driving register-file read, execute and write phases
module cu_seq_decoder #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 5,
    parameter int OPC_W   = 4,
    parameter int FLAG_W  = 4,
    parameter int INSTR_W = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               instr_vld,
    output logic               instr_rdy,
    output logic [DATA_W-1:0]  data_o,
    output logic [ADDR_W-1:0]  addr_o,
    output logic [OPC_W-1:0]   opcode_o,
    output logic [FLAG_W-1:0]  flags_o,
    output logic               imm_sel,
    output logic               rd_en,
    input  logic               rd_ack,
    output logic               exec_en,
    input  logic               exec_ack,
    output logic               wr_en,
    input  logic               wr_ack,
    output logic               done,
    output logic               err,
    output logic [CNT_W-1:0]   retired
);

    // Field positions, LSB upward: flags | opcode | li | wr | rd | addr | data
    localparam int LI_B   = FLAG_W + OPC_W;
    localparam int WR_B   = LI_B + 1;
    localparam int RD_B   = LI_B + 2;
    localparam int ADDR_B = LI_B + 3;
    localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    if (INSTR_W != DATA_W + ADDR_W + 3 + OPC_W + FLAG_W) begin : g_bad_instr_w
        $error("cu_seq_decoder: INSTR_W does not match the sum of the field widths");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("cu_seq_decoder: TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_READ,
        S_EXEC,
        S_WRITE
    } state_t;

    state_t              state_q, state_d;
    logic [INSTR_W-1:0]  ir_q;
    logic [DATA_W-1:0]   data_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [OPC_W-1:0]    opcode_q;
    logic [FLAG_W-1:0]   flags_q;
    logic                imm_q;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                done_q, err_q;
    logic [CNT_W-1:0]    retired_q;
    logic                tmo_hit;
    logic                retire;
    logic                abort;
    logic                busy;

    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));
    assign busy    = (state_q == S_READ) || (state_q == S_EXEC) || (state_q == S_WRITE);

    // State register and wait counter; the counter restarts on every state change
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state: sequence phases, retire on final ack, abort when the wait expires
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        abort   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (instr_vld) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (ir_q[LI_B])      state_d = S_EXEC;
                else if (ir_q[RD_B]) state_d = S_READ;
                else                 state_d = S_EXEC;
            end
            S_READ: begin
                if (rd_ack) begin
                    state_d = S_EXEC;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                    abort   = 1'b1;
                end
            end
            S_EXEC: begin
                if (exec_ack) begin
                    if (ir_q[WR_B]) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_IDLE;
                        retire  = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                    abort   = 1'b1;
                end
            end
            S_WRITE: begin
                if (wr_ack) begin
                    state_d = S_IDLE;
                    retire  = 1'b1;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                    abort   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A busy state that does not change has seen no ack this cycle
        if (state_d != state_q) tmo_d = '0;
        else if (busy)          tmo_d = tmo_q + TMO_W'(1);
        else                    tmo_d = '0;
    end

    // Moore outputs: ready and request strobes depend on state only
    always_comb begin
        instr_rdy = (state_q == S_IDLE);
        rd_en     = (state_q == S_READ);
        exec_en   = (state_q == S_EXEC);
        wr_en     = (state_q == S_WRITE);
    end

    // Instruction register on accept; decoded fields register during DECODE
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q     <= '0;
            data_q   <= '0;
            addr_q   <= '0;
            opcode_q <= '0;
            flags_q  <= '0;
            imm_q    <= 1'b0;
        end else begin
            if (state_q == S_IDLE && instr_vld) ir_q <= instr_i;
            if (state_q == S_DECODE) begin
                data_q   <= ir_q[INSTR_W-1 -: DATA_W];
                addr_q   <= ir_q[ADDR_B +: ADDR_W];
                opcode_q <= ir_q[FLAG_W +: OPC_W];
                flags_q  <= ir_q[0 +: FLAG_W];
                imm_q    <= ir_q[LI_B];
            end
        end
    end

    // Completion pulses land in the IDLE cycle that follows; retired wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            done_q <= retire;
            err_q  <= abort;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign data_o   = data_q;
    assign addr_o   = addr_q;
    assign opcode_o = opcode_q;
    assign flags_o  = flags_q;
    assign imm_sel  = imm_q;
    assign done     = done_q;
    assign err      = err_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_cu_seq_decoder.sv
// tb/tb_cu_seq_decoder.sv - scoreboard bench for cu_seq_decoder
module tb_cu_seq_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_i;
    logic        instr_vld;
    logic        instr_rdy;
    logic [15:0] data_o;
    logic [4:0]  addr_o;
    logic [3:0]  opcode_o, flags_o;
    logic        imm_sel, rd_en, rd_ack, exec_en, exec_ack, wr_en, wr_ack, done, err;
    logic [15:0] retired;

    // narrow-counter instance sharing all inputs, used to observe counter wrap
    logic        s_instr_rdy, s_imm_sel, s_rd_en, s_exec_en, s_wr_en, s_done, s_err;
    logic [15:0] s_data_o;
    logic [4:0]  s_addr_o;
    logic [3:0]  s_opcode_o, s_flags_o;
    logic [2:0]  s_retired;

    always #5 clk = ~clk;

    cu_seq_decoder u_dut (
        .clk(clk), .reset(reset), .instr_i(instr_i), .instr_vld(instr_vld),
        .instr_rdy(instr_rdy), .data_o(data_o), .addr_o(addr_o), .opcode_o(opcode_o),
        .flags_o(flags_o), .imm_sel(imm_sel), .rd_en(rd_en), .rd_ack(rd_ack),
        .exec_en(exec_en), .exec_ack(exec_ack), .wr_en(wr_en), .wr_ack(wr_ack),
        .done(done), .err(err), .retired(retired)
    );

    cu_seq_decoder #(.CNT_W(3)) u_small (
        .clk(clk), .reset(reset), .instr_i(instr_i), .instr_vld(instr_vld),
        .instr_rdy(s_instr_rdy), .data_o(s_data_o), .addr_o(s_addr_o), .opcode_o(s_opcode_o),
        .flags_o(s_flags_o), .imm_sel(s_imm_sel), .rd_en(s_rd_en), .rd_ack(rd_ack),
        .exec_en(s_exec_en), .exec_ack(exec_ack), .wr_en(s_wr_en), .wr_ack(wr_ack),
        .done(s_done), .err(s_err), .retired(s_retired)
    );

    typedef struct {
        logic        is_err;
        logic [15:0] data;
        logic [4:0]  addr;
        logic [3:0]  opc;
        logic [3:0]  flg;
        logic        imm;
        logic [15:0] ret;
        int          lat;
        int          nrd, nex, nwr;
        logic        b2b;
    } exp_t;

    exp_t        sb[$];
    int          acc_q[$];
    int          n_chk = 0, n_pass = 0;
    int          cyc = 0, last_done = -1;
    int          rd_c = 0, ex_c = 0, wr_c = 0;
    logic        ord_bad = 1'b0;
    logic [15:0] exp_ret = 16'd0;

    int   rd_dly = 0, ex_dly = 0, wr_dly = 0;
    logic rd_blk = 1'b0, ex_blk = 1'b0, wr_blk = 1'b0;
    int   rd_w = 0, ex_w = 0, wr_w = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Ack responders: each ack rises after its request has been high for *_dly cycles
    always @(negedge clk) begin
        if (!rd_en) begin rd_w = 0; rd_ack = 1'b0; end
        else begin rd_ack = !rd_blk && (rd_w >= rd_dly); rd_w++; end
        if (!exec_en) begin ex_w = 0; exec_ack = 1'b0; end
        else begin exec_ack = !ex_blk && (ex_w >= ex_dly); ex_w++; end
        if (!wr_en) begin wr_w = 0; wr_ack = 1'b0; end
        else begin wr_ack = !wr_blk && (wr_w >= wr_dly); wr_w++; end
    end

    // Monitor: counts strobes per instruction and checks each done/err against the scoreboard
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            acc_q.delete();
            rd_c = 0; ex_c = 0; wr_c = 0; ord_bad = 1'b0;
        end else begin
            if (int'(rd_en) + int'(exec_en) + int'(wr_en) > 1) ord_bad = 1'b1;
            if (rd_en && (ex_c != 0 || wr_c != 0)) ord_bad = 1'b1;
            if (exec_en && wr_c != 0) ord_bad = 1'b1;
            if (rd_en) rd_c++;
            if (exec_en) ex_c++;
            if (wr_en) wr_c++;
            if (done || err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_completion", {done, err}, 2'b00);
                end else begin
                    exp_t e;
                    int   a;
                    e = sb.pop_front();
                    a = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
                    chk("kind_done_err", {done, err}, {!e.is_err, e.is_err});
                    chk("decoded_fields", {data_o, addr_o, opcode_o, flags_o, imm_sel},
                        {e.data, e.addr, e.opc, e.flg, e.imm});
                    chk("retired", retired, e.ret);
                    chk("latency", 64'(cyc - a), 64'(e.lat));
                    chk("strobes", {16'(rd_c), 16'(ex_c), 16'(wr_c), 16'(ord_bad)},
                        {16'(e.nrd), 16'(e.nex), 16'(e.nwr), 16'd0});
                    if (e.b2b) chk("b2b_accept_cycle", 64'(a), 64'(last_done));
                end
                last_done = cyc;
                rd_c = 0; ex_c = 0; wr_c = 0; ord_bad = 1'b0;
            end
            if (instr_vld && instr_rdy) acc_q.push_back(cyc);
        end
    end

    task automatic send(input logic [31:0] ins);
        int n;
        instr_i   = ins;
        instr_vld = 1'b1;
        n = 0;
        @(negedge clk);
        while (!instr_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic is_err, input logic [15:0] d,
                         input logic [4:0] a, input logic [3:0] o, input logic [3:0] f,
                         input logic imm, input int lat, input int nrd, input int nex,
                         input int nwr, input logic b2b, input logic hold);
        exp_t e;
        if (!is_err) exp_ret = exp_ret + 16'd1;
        e.is_err = is_err; e.data = d; e.addr = a; e.opc = o; e.flg = f; e.imm = imm;
        e.ret = exp_ret; e.lat = lat; e.nrd = nrd; e.nex = nex; e.nwr = nwr; e.b2b = b2b;
        sb.push_back(e);
        send(ins);
        if (!hold) instr_vld = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n >= 500) chk("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        reset = 1'b1; instr_i = '0; instr_vld = 1'b0;
        rd_ack = 1'b0; exec_ack = 1'b0; wr_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_instr_rdy", instr_rdy, 1'b1);
        chk("rst_strobes", {rd_en, exec_en, wr_en, done, err}, 5'b0);
        chk("rst_fields", {data_o, addr_o, opcode_o, flags_o, imm_sel}, 30'b0);
        chk("rst_retired", retired, 16'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // rd+wr, acks immediate
        issue(32'h12342E3A, 0, 16'h1234, 5'd5, 4'h3, 4'hA, 0, 5, 1, 1, 1, 0, 0);
        drain();
        // li+wr
        issue(32'h00FF0B10, 0, 16'h00FF, 5'd1, 4'h1, 4'h0, 1, 4, 0, 1, 1, 0, 0);
        drain();
        // li with rd set: read phase skipped
        issue(32'hABCDF5C7, 0, 16'hABCD, 5'd30, 4'hC, 4'h7, 1, 3, 0, 1, 0, 0, 0);
        drain();
        // no rd/wr, all-ones fields
        issue(32'hFFFFF8FF, 0, 16'hFFFF, 5'd31, 4'hF, 4'hF, 0, 3, 0, 1, 0, 0, 0);
        drain();

        // read timeout, then ack in the last allowed cycle
        rd_blk = 1'b1;
        issue(32'h55550400, 1, 16'h5555, 5'd0, 4'h0, 4'h0, 0, 18, 16, 0, 0, 0, 0);
        drain();
        rd_blk = 1'b0; rd_dly = 15;
        issue(32'h55550400, 0, 16'h5555, 5'd0, 4'h0, 4'h0, 0, 19, 16, 1, 0, 0, 0);
        drain();
        rd_dly = 0;
        // execute timeout
        ex_blk = 1'b1;
        issue(32'h00010000, 1, 16'h0001, 5'd0, 4'h0, 4'h0, 0, 18, 0, 16, 0, 0, 0);
        drain();
        ex_blk = 1'b0;

        // back-to-back with valid held, acks delayed 2 cycles
        rd_dly = 2; ex_dly = 2; wr_dly = 2;
        issue(32'h12342E3A, 0, 16'h1234, 5'd5, 4'h3, 4'hA, 0, 11, 3, 3, 3, 0, 1);
        issue(32'h00FF0B10, 0, 16'h00FF, 5'd1, 4'h1, 4'h0, 1, 8, 0, 3, 3, 1, 1);
        issue(32'hFFFFF8FF, 0, 16'hFFFF, 5'd31, 4'hF, 4'hF, 0, 5, 0, 3, 0, 1, 0);
        drain();
        rd_dly = 0; ex_dly = 0; wr_dly = 0;
        chk("narrow_counter_wrap", s_retired, 3'd0);

        // reset while waiting in WRITE
        wr_blk = 1'b1;
        send(32'h00000200);
        instr_vld = 1'b0;
        n = 0;
        @(negedge clk);
        while (!wr_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reached_write", wr_en, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_drops_wr_en", {rd_en, exec_en, wr_en, done, err}, 5'b0);
        chk("reset_clears_retired", retired, 16'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        wr_blk = 1'b0;
        exp_ret = 16'd0;
        issue(32'h00000200, 0, 16'h0000, 5'd0, 4'h0, 4'h0, 0, 4, 0, 1, 1, 0, 0);
        drain();
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
